// File: rtl/toast_dmem_responder.sv
// toast_dmem_responder: data-memory slave for a test core.
// Byte-lane RAM at address 0, plus a 16-byte MMIO window at MMIO_BASE
// holding a 64-bit cycle counter (CYC_LO/CYC_HI), a TOHOST register and a
// reserved word. Reads are registered with one cycle of latency and have
// read-first behaviour.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   DMEM_addr_i            byte address (bits [1:0] ignored)
//   DMEM_wr_byte_en_i      per-lane write enables
//   DMEM_wr_data_i         lane-aligned write data
//   DMEM_rst_i             synchronous clear of the read-data register
//   DMEM_rd_data_o         registered read data
//   tohost_o, done_o       TOHOST value and sticky test-complete flag
//   bus_err_o              one-cycle pulse after an unmapped write
module toast_dmem_responder #(
  parameter int unsigned RAM_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] DMEM_addr_i,
  input  logic [3:0]  DMEM_wr_byte_en_i,
  input  logic [31:0] DMEM_wr_data_i,
  input  logic        DMEM_rst_i,
  output logic [31:0] DMEM_rd_data_o,
  output logic [31:0] tohost_o,
  output logic        done_o,
  output logic        bus_err_o
);

  localparam int unsigned ADDR_W    = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;
  localparam logic [1:0]  OFF_CYC_LO = 2'd0;
  localparam logic [1:0]  OFF_CYC_HI = 2'd1;
  localparam logic [1:0]  OFF_TOHOST = 2'd2;

  logic              ram_sel;
  logic              mmio_sel;
  logic              unmapped;
  logic              wr_any;
  logic              tohost_wr;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        mmio_off;
  logic [31:0]       ram_rd;
  logic [31:0]       rd_next;
  logic [31:0]       tohost_merged;
  logic [63:0]       counter;
  logic [31:0]       hi_shadow;
  logic              unused_addr_bits;

  // Address decode; RAM wins if a parameterisation ever overlaps the window
  assign ram_sel          = {1'b0, DMEM_addr_i} < RAM_BYTES;
  assign mmio_sel         = !ram_sel && (DMEM_addr_i[31:4] == MMIO_BASE[31:4]);
  assign unmapped         = !ram_sel && !mmio_sel;
  assign wr_any           = |DMEM_wr_byte_en_i;
  assign word_idx         = DMEM_addr_i[ADDR_W+1:2];
  assign mmio_off         = DMEM_addr_i[3:2];
  assign tohost_wr        = mmio_sel && (mmio_off == OFF_TOHOST) && wr_any;
  assign unused_addr_bits = ^DMEM_addr_i[1:0];

  // Byte-lane RAM; reads see the pre-write contents, rst_i aborts the write
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] mem [RAM_WORDS];

    always_ff @(posedge clk_i) begin
      if (!rst_i && ram_sel && DMEM_wr_byte_en_i[g]) begin
        mem[word_idx] <= DMEM_wr_data_i[8*g +: 8];
      end
    end

    assign ram_rd[8*g +: 8] = mem[word_idx];
  end

  // TOHOST byte-enable merge
  always_comb begin
    tohost_merged = tohost_o;
    for (int i = 0; i < 4; i++) begin
      if (DMEM_wr_byte_en_i[i]) begin
        tohost_merged[8*i +: 8] = DMEM_wr_data_i[8*i +: 8];
      end
    end
  end

  // Read mux
  always_comb begin
    rd_next = 32'h0;
    if (ram_sel) begin
      rd_next = ram_rd;
    end else if (mmio_sel) begin
      case (mmio_off)
        OFF_CYC_LO: rd_next = counter[31:0];
        OFF_CYC_HI: rd_next = hi_shadow;
        OFF_TOHOST: rd_next = tohost_o;
        default:    rd_next = 32'h0;
      endcase
    end
  end

  // Counter, shadow, TOHOST, flags and read-data register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      counter        <= 64'h0;
      hi_shadow      <= 32'h0;
      tohost_o       <= 32'h0;
      done_o         <= 1'b0;
      bus_err_o      <= 1'b0;
      DMEM_rd_data_o <= 32'h0;
    end else begin
      counter <= counter + 64'd1;
      // Reading LO freezes the upper half so a following HI read is coherent
      if (mmio_sel && (mmio_off == OFF_CYC_LO)) begin
        hi_shadow <= counter[63:32];
      end
      if (tohost_wr) begin
        tohost_o <= tohost_merged;
        if (tohost_merged != 32'h0) begin
          done_o <= 1'b1;
        end
      end
      bus_err_o      <= unmapped && wr_any;
      DMEM_rd_data_o <= DMEM_rst_i ? 32'h0 : rd_next;
    end
  end

endmodule
